// File: rtl/sync_ram_pkg.sv
// Shared types and default geometry for the sync_ram block.
package sync_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 12;

endpackage

// File: rtl/sync_ram_array.sv
// Single-port storage: one synchronous write port and one registered read port.
module sync_ram_array
  import sync_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register only loads on a read, so the last result is held otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a full-memory clear sweep after reset or on request.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  readValid,
  input  logic                  clearStart,
  output logic                  busy
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clearCount;
  logic                  r_readValid;

  logic                  w_accept;
  logic                  w_we;
  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign reqReady  = (r_state == IDLE);
  assign busy      = (r_state == CLEAR);
  assign readValid = r_readValid;
  assign w_accept  = reqValid && reqReady && !reset;

  // The single array port is owned by the sweep in CLEAR and by requests in IDLE.
  always_comb begin
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_addr  = address;
    w_wdata = writeData;
    if (!reset) begin
      if (r_state == CLEAR) begin
        w_we    = 1'b1;
        w_addr  = r_clearCount;
        w_wdata = CLEAR_VALUE;
      end else if (w_accept) begin
        w_we = reqWrite;
        w_re = !reqWrite;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_clearCount <= '0;
      r_readValid  <= 1'b0;
    end else begin
      r_readValid <= w_re;
      if (r_state == CLEAR) begin
        r_clearCount <= r_clearCount + ADDR_WIDTH'(1);
        if (r_clearCount == '1) begin
          r_state <= IDLE;
        end
      end else if (clearStart) begin
        r_state      <= CLEAR;
        r_clearCount <= '0;
      end
    end
  end

  sync_ram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .i_clk  (clock),
    .i_rst  (reset),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_rdata(readData)
  );

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: cycle-by-cycle reference model plus directed literal checks.
module tb_sync_ram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned BOUND = 10000;

  logic          clock = 1'b0;
  logic          reset;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData;
  logic          readValid;
  logic          clearStart;
  logic          busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        chk_en  = 1'b0;

  sync_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CLEAR_VALUE(8'h00)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .address   (address),
    .writeData (writeData),
    .readData  (readData),
    .readValid (readValid),
    .clearStart(clearStart),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an array, sweep as a countdown of busy cycles.
  // Memory is cleared wholesale when a sweep starts, since nothing can touch it mid-sweep.
  logic [DW-1:0] m_mem [DEPTH];
  int unsigned   m_left = 0;
  logic          m_rv   = 1'b0;
  logic [DW-1:0] m_rd   = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_left = DEPTH;
      m_rv   = 1'b0;
      m_rd   = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else begin
      m_rv = 1'b0;
      if (m_left == 0) begin
        if (reqValid) begin
          if (reqWrite) m_mem[address] = writeData;
          else begin
            m_rv = 1'b1;
            m_rd = m_mem[address];
          end
        end
        if (clearStart) begin
          m_left = DEPTH;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        end
      end else begin
        m_left = m_left - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy",      32'(busy),      32'(m_left != 0));
      check("cyc_reqReady",  32'(reqReady),  32'(m_left == 0));
      check("cyc_readValid", 32'(readValid), 32'(m_rv));
      check("cyc_readData",  32'(readData),  32'(m_rd));
    end
  end

  task automatic wait_busy(input int unsigned exp_cycles, input string name);
    int unsigned n = 0;
    while (busy && n < BOUND) begin
      n++;
      @(negedge clock);
    end
    check(name, n, exp_cycles);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    reqValid = 1'b1; reqWrite = 1'b1; address = a; writeData = d;
    @(negedge clock);
    reqValid = 1'b0; reqWrite = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    reqValid = 1'b1; reqWrite = 1'b0; address = a;
    @(negedge clock);
    reqValid = 1'b0;
    check({name, "_rv"}, 32'(readValid), 32'd1);
    check({name, "_rd"}, 32'(readData), 32'(exp));
  endtask

  task automatic start_sweep();
    clearStart = 1'b1;
    @(negedge clock);
    clearStart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cnt;
    int unsigned pulses;
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; address = '0;
    writeData = '0; clearStart = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(reqReady), 32'd0);
    check("rst_rv", 32'(readValid), 32'd0);
    check("rst_rd", 32'(readData), 32'd0);
    reset = 1'b0;
    wait_busy(4096, "init_sweep_len");
    check("init_ready", 32'(reqReady), 32'd1);

    do_read(12'h000, 8'h00, "rd000");
    do_read(12'h7FF, 8'h00, "rd7FF");
    do_read(12'hFFF, 8'h00, "rdFFF");

    do_write(12'h123, 8'hA5);
    do_read(12'h123, 8'hA5, "wr_rd123");
    @(negedge clock);
    check("hold_rv", 32'(readValid), 32'd0);
    check("hold_rd", 32'(readData), 32'hA5);

    do_write(12'h001, 8'h11);
    do_write(12'h002, 8'h22);
    do_write(12'h003, 8'h33);
    reqValid = 1'b1; reqWrite = 1'b0; address = 12'h001;
    @(negedge clock);
    address = 12'h002;
    check("b2b0_rv", 32'(readValid), 32'd1); check("b2b0_rd", 32'(readData), 32'h11);
    @(negedge clock);
    address = 12'h003;
    check("b2b1_rv", 32'(readValid), 32'd1); check("b2b1_rd", 32'(readData), 32'h22);
    @(negedge clock);
    reqValid = 1'b0;
    check("b2b2_rv", 32'(readValid), 32'd1); check("b2b2_rd", 32'(readData), 32'h33);
    @(negedge clock);
    check("b2b_end_rv", 32'(readValid), 32'd0);

    // Read accepted together with clearStart still responds.
    do_write(12'h050, 8'h99);
    clearStart = 1'b1;
    do_read(12'h050, 8'h99, "rd_on_clear");
    clearStart = 1'b0;
    check("rd_on_clear_busy", 32'(busy), 32'd1);
    wait_busy(4096, "clr_read_sweep_len");

    // Write accepted together with clearStart is overwritten by the sweep.
    do_write(12'h010, 8'h77);
    clearStart = 1'b1;
    do_write(12'h010, 8'h5A);
    clearStart = 1'b0;
    check("wr_on_clear_ready", 32'(reqReady), 32'd0);
    wait_busy(4096, "clr_write_sweep_len");
    do_read(12'h010, 8'h00, "rd010_cleared");

    // Reset mid-sweep restarts the sweep.
    start_sweep();
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_busy(4096, "reset_restart_len");

    // clearStart mid-sweep is ignored.
    start_sweep();
    cnt = 0;
    while (busy && cnt < BOUND) begin
      clearStart = (cnt == 50);
      cnt++;
      @(negedge clock);
    end
    clearStart = 1'b0;
    check("clr_ignored_len", cnt, 32'd4096);

    // Reset alongside a read cancels its response.
    do_write(12'h001, 8'h44);
    reqValid = 1'b1; reqWrite = 1'b0; address = 12'h001; reset = 1'b1;
    @(negedge clock);
    reqValid = 1'b0; reset = 1'b0;
    check("rst_cancel_rv", 32'(readValid), 32'd0);
    check("rst_cancel_rd", 32'(readData), 32'd0);
    wait_busy(4096, "rst_cancel_sweep_len");

    // Write held through a sweep lands once the block is ready.
    start_sweep();
    reqValid = 1'b1; reqWrite = 1'b1; address = 12'h200; writeData = 8'h3C;
    cnt = 0;
    while (!reqReady && cnt < BOUND) begin
      cnt++;
      @(negedge clock);
    end
    check("held_wr_wait", cnt, 32'd4096);
    @(negedge clock);
    reqValid = 1'b0; reqWrite = 1'b0;
    do_read(12'h200, 8'h3C, "held_wr_rd");

    // Read held through a sweep responds exactly once.
    start_sweep();
    reqValid = 1'b1; reqWrite = 1'b0; address = 12'h200;
    cnt = 0; pulses = 0;
    while (!reqReady && cnt < BOUND) begin
      pulses += 32'(readValid);
      cnt++;
      @(negedge clock);
    end
    @(negedge clock);
    reqValid = 1'b0;
    repeat (3) begin
      pulses += 32'(readValid);
      @(negedge clock);
    end
    check("held_rd_pulses", pulses, 32'd1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
